// File: rtl/srp_capture_ctrl.sv
// srp_capture_ctrl: captures one frame of DEPTH 32-bit samples into an
// external BRAM, then serves random-access readout of the frame.
// Optional feature: define SRP_CAPTURE_OVF_EN to count samples that arrive
// while no capture is running. Without it, ovf_cnt is tied to zero.
module srp_capture_ctrl #(
    parameter int DEPTH  = 2096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       ovf_cnt,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              rd_pend;
    logic              rd_pend_next;
    logic              rd_oob;
    logic              rd_oob_next;
    logic [31:0]       rd_hold;
    logic              addr_in_range;

    assign addr_in_range = (32'(rd_addr) < 32'(DEPTH));

    // Next-state, pointer and BRAM port decode; reset suppresses every access
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_di      = '0;
        rd_pend_next = 1'b0;
        rd_oob_next  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = CAPTURE;
                        ptr_next   = '0;
                    end
                end
                CAPTURE: begin
                    if (s_valid) begin
                        bram_en   = 1'b1;
                        bram_we   = 1'b1;
                        bram_addr = ptr;
                        bram_di   = s_data;
                        if (ptr == LAST_ADDR) begin
                            state_next = READY;
                            ptr_next   = '0;
                        end else begin
                            ptr_next = ptr + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (start) begin
                        state_next = CAPTURE;
                        ptr_next   = '0;
                    end else if (rd_req) begin
                        rd_pend_next = 1'b1;
                        if (addr_in_range) begin
                            bram_en   = 1'b1;
                            bram_addr = rd_addr;
                        end else begin
                            rd_oob_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, pointer, status flags and the one-deep read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_pend <= 1'b0;
            rd_oob  <= 1'b0;
            rd_hold <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            busy    <= (state_next == CAPTURE);
            done    <= (state_next == READY);
            rd_pend <= rd_pend_next;
            rd_oob  <= rd_oob_next;
            if (rd_pend) begin
                rd_hold <= rd_data;
            end
        end
    end

    assign rd_valid = rd_pend;
    assign rd_data  = rd_pend ? (rd_oob ? 32'd0 : bram_dout) : rd_hold;

`ifdef SRP_CAPTURE_OVF_EN
    logic [15:0] ovf_q;

    // Count samples dropped outside a capture, saturating; a new capture clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (start && (state != CAPTURE)) begin
            ovf_q <= '0;
        end else if (s_valid && (state != CAPTURE) && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_srp_capture_ctrl.sv
// Testbench for srp_capture_ctrl: full-frame captures with a behavioural
// BRAM, a reset-abandoned frame, table-driven readout vectors and the
// dropped-sample counter.
module tb_srp_capture_ctrl;

    localparam int DEPTH  = 2096;
    localparam int ADDR_W = 12;

`ifdef SRP_CAPTURE_OVF_EN
    localparam logic [15:0] OVF_IDLE_EXP  = 16'd3;
    localparam logic [15:0] OVF_READY_EXP = 16'd5;
`else
    localparam logic [15:0] OVF_IDLE_EXP  = 16'd0;
    localparam logic [15:0] OVF_READY_EXP = 16'd0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              busy;
    logic              done;
    logic [15:0]       ovf_cnt;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_di;
    logic [31:0]       bram_dout;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks;
    int errors;

    typedef struct {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              exp_en;
        logic              exp_valid;
        logic [31:0]       exp_data;
    } vec_t;

    vec_t vecs [10];

    srp_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ovf_cnt   (ovf_cnt),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_dout (bram_dout)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port BRAM with one-cycle read latency
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_di;
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic st, input logic sv, input logic [31:0] sd,
                                  input logic rq, input logic [ADDR_W-1:0] ra);
        start   = st;
        s_valid = sv;
        s_data  = sd;
        rd_req  = rq;
        rd_addr = ra;
        #1;
    endtask

    // Stream n samples with data = index, with periodic idle cycles carrying a
    // stray rd_req; optionally pulse start alongside word start_at.
    task automatic capture_words(input int n, input int start_at);
        for (int idx = 0; idx < n; idx++) begin
            if ((idx % 7) == 3) begin
                apply_stimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, ADDR_W'(idx));
                check_output("idle_bram_en", {31'd0, bram_en}, 32'd0);
                tick();
                check_output("capture_rd_valid", {31'd0, rd_valid}, 32'd0);
            end
            apply_stimulus(idx == start_at, 1'b1, 32'(idx), 1'b0, '0);
            check_output("wr_en_we", {30'd0, bram_en, bram_we}, 32'd3);
            check_output("wr_addr", 32'(bram_addr), 32'(idx));
            check_output("wr_di", bram_di, 32'(idx));
            if (idx == n - 1) begin
                check_output("last_wr_busy_done", {30'd0, busy, done}, 32'd2);
            end
            tick();
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bram_dout = '0;
        rst       = 1'b1;
        start     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;

        vecs[0] = '{req: 1'b1, addr: 12'd0,    exp_en: 1'b1, exp_valid: 1'b1, exp_data: 32'd0};
        vecs[1] = '{req: 1'b1, addr: 12'd1,    exp_en: 1'b1, exp_valid: 1'b1, exp_data: 32'd1};
        vecs[2] = '{req: 1'b1, addr: 12'd2095, exp_en: 1'b1, exp_valid: 1'b1, exp_data: 32'd2095};
        vecs[3] = '{req: 1'b1, addr: 12'd2100, exp_en: 1'b0, exp_valid: 1'b1, exp_data: 32'd0};
        vecs[4] = '{req: 1'b0, addr: 12'd5,    exp_en: 1'b0, exp_valid: 1'b0, exp_data: 32'd0};
        vecs[5] = '{req: 1'b1, addr: 12'd7,    exp_en: 1'b1, exp_valid: 1'b1, exp_data: 32'd7};
        vecs[6] = '{req: 1'b0, addr: 12'd9,    exp_en: 1'b0, exp_valid: 1'b0, exp_data: 32'd7};
        vecs[7] = '{req: 1'b1, addr: 12'd2096, exp_en: 1'b0, exp_valid: 1'b1, exp_data: 32'd0};
        vecs[8] = '{req: 1'b1, addr: 12'd1234, exp_en: 1'b1, exp_valid: 1'b1, exp_data: 32'd1234};
        vecs[9] = '{req: 1'b0, addr: 12'd0,    exp_en: 1'b0, exp_valid: 1'b0, exp_data: 32'd1234};

        // Reset state
        tick();
        tick();
        check_output("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check_output("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_output("rst_rd_data", rd_data, 32'd0);
        check_output("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
        check_output("rst_bram", {30'd0, bram_en, bram_we}, 32'd0);
        rst = 1'b0;
        tick();

        // Reads in IDLE are ignored; samples in IDLE are dropped
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 12'd0);
        check_output("idle_rd_bram_en", {31'd0, bram_en}, 32'd0);
        tick();
        check_output("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'(i), 1'b0, '0);
            check_output("idle_sv_bram_en", {31'd0, bram_en}, 32'd0);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("idle_ovf", {16'd0, ovf_cnt}, {16'd0, OVF_IDLE_EXP});

        // Arm a capture; a start mid-frame must not disturb the pointer
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("start_busy_done", {30'd0, busy, done}, 32'd2);
        check_output("start_ovf_clear", {16'd0, ovf_cnt}, 32'd0);
        capture_words(1000, 500);

        // Reset mid-frame together with a sample: no write, frame abandoned
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 32'd1000, 1'b0, '0);
        check_output("rst_sv_bram_en", {31'd0, bram_en}, 32'd0);
        tick();
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("abandon_busy_done", {30'd0, busy, done}, 32'd0);
        check_output("abandon_rd_valid", {31'd0, rd_valid}, 32'd0);

        // Full frame from address 0
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("restart_busy", {31'd0, busy}, 32'd1);
        capture_words(DEPTH, -1);
        check_output("frame_done_busy", {30'd0, busy, done}, 32'd1);

        // Table-driven readout, one vector per cycle back to back
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, vecs[i].req, vecs[i].addr);
            check_output($sformatf("vec%0d_bram_en_we", i), {30'd0, bram_en, bram_we},
                         {30'd0, vecs[i].exp_en, 1'b0});
            if (vecs[i].exp_en) begin
                check_output($sformatf("vec%0d_bram_addr", i), 32'(bram_addr), 32'(vecs[i].addr));
            end
            tick();
            check_output($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
            check_output($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("ready_busy_done", {30'd0, busy, done}, 32'd1);

        // Samples in READY are dropped and counted
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, '0);
            check_output("ready_sv_bram_en", {31'd0, bram_en}, 32'd0);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("ready_ovf", {16'd0, ovf_cnt}, {16'd0, OVF_READY_EXP});

        // start beats rd_req in READY; the read is dropped
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, 12'd1);
        check_output("start_vs_rd_bram_en", {31'd0, bram_en}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
        check_output("start_vs_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_output("rearm_busy_done", {30'd0, busy, done}, 32'd2);
        check_output("rearm_ovf_clear", {16'd0, ovf_cnt}, 32'd0);

        // Reset leaves CAPTURE for IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("final_rst_busy_done", {30'd0, busy, done}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
